// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared definitions for the branch resolve controller.
//  - RV32 branch funct3 encodings (F3_BEQ..F3_BGEU)
//  - FSM state encoding
//  - comparator signed-select polarity
//  - helpers that decode a funct3 into a taken condition / illegal flag
package branch_resolve_ctrl_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic CMP_SIGNED = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EVAL  = 2'd1,
    ST_REDIR = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  // Branch condition from the comparator flags. Encodings 010/011 are not
  // branches and resolve as not-taken.
  function automatic logic br_cond(input logic [2:0] f3, input logic eq, input logic lt);
    logic r;
    r = 1'b0;
    case (f3)
      F3_BEQ:           r = eq;
      F3_BNE:           r = ~eq;
      F3_BLT, F3_BLTU:  r = lt;
      F3_BGE, F3_BGEU:  r = ~lt;
      default:          r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic f3_illegal(input logic [2:0] f3);
    return (f3[2:1] == 2'b01);
  endfunction

endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// Signal bundle between the EX stage / fetch and the branch resolve controller.
//  slave  : view taken by branch_resolve_ctrl
//  master : view taken by the surrounding pipeline (or a testbench)
// Request side : br_valid_i/br_ready_o, funct3, pc, imm, rs1, rs2, kill_i
// Comparator   : cmp_a_o, cmp_b_o, cmp_signed_o out; cmp_eq_i, cmp_lt_i back
// Fetch side   : redir_valid_o/redir_ready_i, redir_pc_o, flush_o
// Status       : done_o, taken_o, misalign_o, illegal_o, cnt_br_o, cnt_taken_o
interface branch_resolve_ctrl_if #(
  parameter int WID_DATA = 32,
  parameter int CNT_W    = 16
);

  logic                br_valid_i;
  logic                br_ready_o;
  logic [2:0]          br_funct3_i;
  logic [WID_DATA-1:0] br_pc_i;
  logic [WID_DATA-1:0] br_imm_i;
  logic [WID_DATA-1:0] br_rs1_i;
  logic [WID_DATA-1:0] br_rs2_i;
  logic                kill_i;
  logic [WID_DATA-1:0] cmp_a_o;
  logic [WID_DATA-1:0] cmp_b_o;
  logic                cmp_signed_o;
  logic                cmp_eq_i;
  logic                cmp_lt_i;
  logic                redir_valid_o;
  logic                redir_ready_i;
  logic [WID_DATA-1:0] redir_pc_o;
  logic                flush_o;
  logic                done_o;
  logic                taken_o;
  logic                misalign_o;
  logic                illegal_o;
  logic [CNT_W-1:0]    cnt_br_o;
  logic [CNT_W-1:0]    cnt_taken_o;

  modport slave (
    input  br_valid_i, br_funct3_i, br_pc_i, br_imm_i, br_rs1_i, br_rs2_i, kill_i,
           cmp_eq_i, cmp_lt_i, redir_ready_i,
    output br_ready_o, cmp_a_o, cmp_b_o, cmp_signed_o, redir_valid_o, redir_pc_o,
           flush_o, done_o, taken_o, misalign_o, illegal_o, cnt_br_o, cnt_taken_o
  );

  modport master (
    output br_valid_i, br_funct3_i, br_pc_i, br_imm_i, br_rs1_i, br_rs2_i, kill_i,
           cmp_eq_i, cmp_lt_i, redir_ready_i,
    input  br_ready_o, cmp_a_o, cmp_b_o, cmp_signed_o, redir_valid_o, redir_pc_o,
           flush_o, done_o, taken_o, misalign_o, illegal_o, cnt_br_o, cnt_taken_o
  );

endinterface

// File: rtl/branch_resolve_ctrl_sat_counter.sv
// Saturating up-counter: increments by one when inc is high, holds at
// all-ones, never wraps.
//  clk   in  rising-edge clock
//  rst_n in  asynchronous active-low reset (count -> 0)
//  inc   in  increment request
//  cnt   out current count
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= sat_inc(cnt);
    end
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolve controller for the EX stage. Accepts one conditional branch,
// drives the shared external comparator from latched operands, resolves the
// condition, and for an aligned taken branch holds a redirect to fetch until
// accepted, then raises flush_o for FLUSH_CYC cycles. Keeps saturating
// counts of resolved and redirected branches.
//  clk, rst_n : clock, asynchronous active-low reset
//  bus        : branch_resolve_ctrl_if.slave (request, comparator, fetch, status)
module branch_resolve_ctrl
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int WID_DATA  = 32,
  parameter int FLUSH_CYC = 2,
  parameter int CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  branch_resolve_ctrl_if.slave  bus
);

  localparam int FC_W = $clog2(FLUSH_CYC + 1);

  state_t              state, state_nxt;
  logic [2:0]          f3_p0;
  logic [WID_DATA-1:0] rs1_p0, rs2_p0, tgt_p0;
  logic [FC_W-1:0]     fcnt;

  logic accept, cond_taken, misaligned;
  logic done_nxt, taken_nxt, misalign_nxt, illegal_nxt;
  logic inc_br, inc_taken, fcnt_load;
  logic done_q, taken_q, misalign_q, illegal_q;

  assign accept     = (state == ST_IDLE) & bus.br_valid_i & ~bus.kill_i;
  assign cond_taken = br_cond(f3_p0, bus.cmp_eq_i, bus.cmp_lt_i);
  assign misaligned = (tgt_p0[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    done_nxt     = 1'b0;
    taken_nxt    = 1'b0;
    misalign_nxt = 1'b0;
    illegal_nxt  = 1'b0;
    inc_br       = 1'b0;
    inc_taken    = 1'b0;
    fcnt_load    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) state_nxt = ST_EVAL;
      end
      ST_EVAL: begin
        if (bus.kill_i) begin
          state_nxt = ST_IDLE;
        end else if (!cond_taken) begin
          state_nxt   = ST_IDLE;
          done_nxt    = 1'b1;
          illegal_nxt = f3_illegal(f3_p0);
          inc_br      = 1'b1;
        end else if (misaligned) begin
          // Taken but unreachable target: report, never redirect.
          state_nxt    = ST_IDLE;
          done_nxt     = 1'b1;
          taken_nxt    = 1'b1;
          misalign_nxt = 1'b1;
          inc_br       = 1'b1;
        end else begin
          state_nxt = ST_REDIR;
        end
      end
      ST_REDIR: begin
        // kill_i takes priority over a coincident redirect handshake.
        if (bus.kill_i) begin
          state_nxt = ST_IDLE;
        end else if (bus.redir_ready_i) begin
          state_nxt = ST_FLUSH;
          done_nxt  = 1'b1;
          taken_nxt = 1'b1;
          inc_br    = 1'b1;
          inc_taken = 1'b1;
          fcnt_load = 1'b1;
        end
      end
      ST_FLUSH: begin
        // kill_i deliberately ignored: the flush window always completes.
        if (fcnt == FC_W'(1)) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request capture: operands and target held for the whole branch lifetime.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f3_p0  <= '0;
      rs1_p0 <= '0;
      rs2_p0 <= '0;
      tgt_p0 <= '0;
    end else if (accept) begin
      f3_p0  <= bus.br_funct3_i;
      rs1_p0 <= bus.br_rs1_i;
      rs2_p0 <= bus.br_rs2_i;
      tgt_p0 <= bus.br_pc_i + bus.br_imm_i;
    end
  end

  // Flush window counter and registered status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt       <= '0;
      done_q     <= 1'b0;
      taken_q    <= 1'b0;
      misalign_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      if (fcnt_load) begin
        fcnt <= FC_W'(FLUSH_CYC);
      end else if (state == ST_FLUSH && fcnt != '0) begin
        fcnt <= fcnt - FC_W'(1);
      end
      done_q     <= done_nxt;
      taken_q    <= taken_nxt;
      misalign_q <= misalign_nxt;
      illegal_q  <= illegal_nxt;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_cnt_br (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc_br),
    .cnt   (bus.cnt_br_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt_taken (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc_taken),
    .cnt   (bus.cnt_taken_o)
  );

  // State-decoded outputs clear immediately on async reset.
  assign bus.br_ready_o    = (state == ST_IDLE);
  assign bus.cmp_a_o       = rs1_p0;
  assign bus.cmp_b_o       = rs2_p0;
  assign bus.cmp_signed_o  = (state == ST_EVAL) & (f3_p0[1] ? ~CMP_SIGNED : CMP_SIGNED);
  assign bus.redir_valid_o = (state == ST_REDIR);
  assign bus.redir_pc_o    = tgt_p0;
  assign bus.flush_o       = (state == ST_FLUSH);
  assign bus.done_o        = done_q;
  assign bus.taken_o       = taken_q;
  assign bus.misalign_o    = misalign_q;
  assign bus.illegal_o     = illegal_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed testbench for branch_resolve_ctrl with a behavioural comparator.
module tb_branch_resolve_ctrl;

  localparam int WID_DATA  = 32;
  localparam int FLUSH_CYC = 2;
  localparam int CNT_W     = 4;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  branch_resolve_ctrl_if #(.WID_DATA(WID_DATA), .CNT_W(CNT_W)) bus ();

  branch_resolve_ctrl #(
    .WID_DATA  (WID_DATA),
    .FLUSH_CYC (FLUSH_CYC),
    .CNT_W     (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // External comparator model
  assign bus.cmp_eq_i = (bus.cmp_a_o == bus.cmp_b_o);
  assign bus.cmp_lt_i = bus.cmp_signed_o ? ($signed(bus.cmp_a_o) < $signed(bus.cmp_b_o))
                                         : (bus.cmp_a_o < bus.cmp_b_o);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                       input logic [31:0] rs1, input logic [31:0] rs2);
    bus.br_valid_i  = 1'b1;
    bus.br_funct3_i = f3;
    bus.br_pc_i     = pc;
    bus.br_imm_i    = imm;
    bus.br_rs1_i    = rs1;
    bus.br_rs2_i    = rs2;
    step();
    bus.br_valid_i  = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus.br_valid_i    = 1'b0;
    bus.br_funct3_i   = 3'b000;
    bus.br_pc_i       = '0;
    bus.br_imm_i      = '0;
    bus.br_rs1_i      = '0;
    bus.br_rs2_i      = '0;
    bus.kill_i        = 1'b0;
    bus.redir_ready_i = 1'b0;
    step();
    step();
    #2 rst_n = 1'b1;
    step();

    // Reset state
    chk_val("rst_ready",    bus.br_ready_o, 1);
    chk_val("rst_redir_v",  bus.redir_valid_o, 0);
    chk_val("rst_flush",    bus.flush_o, 0);
    chk_val("rst_done",     bus.done_o, 0);
    chk_val("rst_signed",   bus.cmp_signed_o, 0);
    chk_val("rst_redir_pc", bus.redir_pc_o, 0);
    chk_val("rst_cnt_br",   bus.cnt_br_o, 0);
    chk_val("rst_cnt_tk",   bus.cnt_taken_o, 0);

    // 1: BEQ taken, pc 0x100 + 0x20
    issue(3'b000, 32'h100, 32'h20, 32'h5, 32'h5);
    chk_val("t1_signed", bus.cmp_signed_o, 1);
    chk_val("t1_ready",  bus.br_ready_o, 0);
    chk_val("t1_cmp_a",  bus.cmp_a_o, 32'h5);
    step();
    chk_val("t1_redir_v",  bus.redir_valid_o, 1);
    chk_val("t1_redir_pc", bus.redir_pc_o, 32'h120);
    chk_val("t1_done_pre", bus.done_o, 0);
    bus.redir_ready_i = 1'b1;
    step();
    bus.redir_ready_i = 1'b0;
    chk_val("t1_done",    bus.done_o, 1);
    chk_val("t1_taken",   bus.taken_o, 1);
    chk_val("t1_flush1",  bus.flush_o, 1);
    chk_val("t1_redir_0", bus.redir_valid_o, 0);
    chk_val("t1_cnt_tk",  bus.cnt_taken_o, 1);
    chk_val("t1_cnt_br",  bus.cnt_br_o, 1);
    step();
    chk_val("t1_flush2",  bus.flush_o, 1);
    chk_val("t1_done_1c", bus.done_o, 0);
    step();
    chk_val("t1_flush_end", bus.flush_o, 0);
    chk_val("t1_ready_end", bus.br_ready_o, 1);

    // 2: BLT signed taken, then BLTU not taken
    issue(3'b100, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'h1);
    chk_val("t2_blt_signed", bus.cmp_signed_o, 1);
    step();
    chk_val("t2_blt_redir", bus.redir_valid_o, 1);
    chk_val("t2_blt_pc",    bus.redir_pc_o, 32'h240);
    bus.redir_ready_i = 1'b1;
    step();
    bus.redir_ready_i = 1'b0;
    step();
    step();
    issue(3'b110, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'h1);
    chk_val("t2_bltu_signed", bus.cmp_signed_o, 0);
    chk_val("t2_bltu_done0",  bus.done_o, 0);
    step();
    chk_val("t2_bltu_done",  bus.done_o, 1);
    chk_val("t2_bltu_taken", bus.taken_o, 0);
    chk_val("t2_bltu_redir", bus.redir_valid_o, 0);
    chk_val("t2_bltu_ready", bus.br_ready_o, 1);
    chk_val("t2_cnt_br",     bus.cnt_br_o, 3);
    chk_val("t2_cnt_tk",     bus.cnt_taken_o, 2);

    // 3: BNE taken, fetch stalls 5 cycles
    issue(3'b001, 32'h300, 32'h10, 32'h1, 32'h2);
    step();
    for (int i = 0; i < 5; i++) begin
      chk_val("t3_redir_v",  bus.redir_valid_o, 1);
      chk_val("t3_redir_pc", bus.redir_pc_o, 32'h310);
      chk_val("t3_ready",    bus.br_ready_o, 0);
      step();
    end
    bus.redir_ready_i = 1'b1;
    step();
    bus.redir_ready_i = 1'b0;
    chk_val("t3_done",   bus.done_o, 1);
    chk_val("t3_cnt_tk", bus.cnt_taken_o, 3);
    step();
    step();

    // 4: kill in IDLE (not accepted), in EVAL, and in REDIR with redir_ready
    bus.kill_i = 1'b1;
    issue(3'b000, 32'h100, 32'h20, 32'h7, 32'h7);
    bus.kill_i = 1'b0;
    chk_val("t4_idle_kill_ready", bus.br_ready_o, 1);
    issue(3'b000, 32'h100, 32'h20, 32'h7, 32'h7);
    bus.kill_i = 1'b1;
    step();
    bus.kill_i = 1'b0;
    chk_val("t4_eval_ready", bus.br_ready_o, 1);
    chk_val("t4_eval_done",  bus.done_o, 0);
    chk_val("t4_eval_redir", bus.redir_valid_o, 0);
    issue(3'b000, 32'h100, 32'h20, 32'h7, 32'h7);
    step();
    chk_val("t4_in_redir", bus.redir_valid_o, 1);
    bus.kill_i        = 1'b1;
    bus.redir_ready_i = 1'b1;
    step();
    bus.kill_i        = 1'b0;
    bus.redir_ready_i = 1'b0;
    chk_val("t4_redir_v",  bus.redir_valid_o, 0);
    chk_val("t4_flush",    bus.flush_o, 0);
    chk_val("t4_done",     bus.done_o, 0);
    chk_val("t4_ready",    bus.br_ready_o, 1);
    chk_val("t4_cnt_br",   bus.cnt_br_o, 4);
    chk_val("t4_cnt_tk",   bus.cnt_taken_o, 3);

    // 5: illegal funct3, then misaligned taken target 0x102
    issue(3'b010, 32'h100, 32'h20, 32'h9, 32'h9);
    step();
    chk_val("t5_illegal", bus.illegal_o, 1);
    chk_val("t5_ill_done", bus.done_o, 1);
    chk_val("t5_ill_taken", bus.taken_o, 0);
    chk_val("t5_ill_redir", bus.redir_valid_o, 0);
    step();
    chk_val("t5_ill_pulse", bus.illegal_o, 0);
    issue(3'b000, 32'h100, 32'h2, 32'h9, 32'h9);
    step();
    chk_val("t5_misalign",  bus.misalign_o, 1);
    chk_val("t5_mis_done",  bus.done_o, 1);
    chk_val("t5_mis_taken", bus.taken_o, 1);
    chk_val("t5_mis_redir", bus.redir_valid_o, 0);
    chk_val("t5_mis_ready", bus.br_ready_o, 1);
    chk_val("t5_cnt_br",    bus.cnt_br_o, 6);
    chk_val("t5_cnt_tk",    bus.cnt_taken_o, 3);
    step();
    chk_val("t5_mis_pulse", bus.misalign_o, 0);
    chk_val("t5_mis_redir2", bus.redir_valid_o, 0);

    // 6: saturation with 20 taken branches, then async reset mid-FLUSH
    for (int i = 0; i < 20; i++) begin
      issue(3'b101, 32'h400, 32'h8, 32'h3, 32'h3);
      step();
      bus.redir_ready_i = 1'b1;
      step();
      bus.redir_ready_i = 1'b0;
      step();
      step();
    end
    chk_val("t6_cnt_br_sat", bus.cnt_br_o, 4'hF);
    chk_val("t6_cnt_tk_sat", bus.cnt_taken_o, 4'hF);
    issue(3'b000, 32'h400, 32'h8, 32'h3, 32'h3);
    step();
    bus.redir_ready_i = 1'b1;
    step();
    bus.redir_ready_i = 1'b0;
    chk_val("t6_sat_hold", bus.cnt_taken_o, 4'hF);
    chk_val("t6_in_flush", bus.flush_o, 1);
    #1 rst_n = 1'b0;
    #1;
    chk_val("t6_rst_flush",   bus.flush_o, 0);
    chk_val("t6_rst_redir_v", bus.redir_valid_o, 0);
    chk_val("t6_rst_ready",   bus.br_ready_o, 1);
    chk_val("t6_rst_done",    bus.done_o, 0);
    chk_val("t6_rst_taken",   bus.taken_o, 0);
    chk_val("t6_rst_pc",      bus.redir_pc_o, 0);
    chk_val("t6_rst_cnt_br",  bus.cnt_br_o, 0);
    chk_val("t6_rst_cnt_tk",  bus.cnt_taken_o, 0);
    step();
    rst_n = 1'b1;
    step();
    chk_val("t6_post_ready", bus.br_ready_o, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
